// File: rtl/bcd_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_pkg
// Shared constants and helpers for the cascaded BCD up/down counter.
//   DIGIT_W  : width of one BCD decade (nibble)
//   BCD_MAX  : largest legal decade value (9)
//   BCD_MIN  : smallest legal decade value (0)
//   is_bcd() : 1 when a nibble holds a legal decimal digit 0..9
// ---------------------------------------------------------------------------
package bcd_updown_counter_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter. Priority inside the decade is
// clear > load > step, so the top level can drive step without
// masking it against clr/load.
// Ports:
//   clk, rst_asyn_n : clock and asynchronous active-low reset
//   clr             : synchronous clear to 0
//   step            : advance one position in the direction up_dn
//   up_dn           : 1 = increment, 0 = decrement
//   load, load_nib  : synchronous load; illegal nibbles load as 0
//   digit           : registered decade value
//   at_max, at_min  : decade currently holds 9 / 0
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_asyn_n,
  input  logic               clr,
  input  logic               step,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_nib,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_min
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next decade value. An illegal present value (only reachable by
  // corruption) simply steps as plain binary; no recovery is attempted.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = is_bcd(load_nib) ? load_nib : BCD_MIN;
    end else if (step) begin
      if (up_dn) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_asyn_n) begin
    if (!rst_asyn_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
// Parametrised multi-decade BCD up/down counter with clear, load, enable,
// wrap or saturate behaviour, terminal count and sticky flags.
// Parameters:
//   DIGITS   : number of decades (1..8)
//   SATURATE : 0 = wrap at terminal value, 1 = hold at terminal value
// Ports:
//   clk, rst_asyn_n : clock and asynchronous active-low reset
//   en              : count enable
//   up_dn           : 1 = up, 0 = down
//   clr             : synchronous clear of count and flags
//   load, load_val  : synchronous parallel load, digit 0 in bits [3:0]
//   q_out           : registered BCD count, same packing as load_val
//   tc              : en & count at terminal value for current direction
//   ovf             : sticky, count wrapped or saturated while enabled
//   load_err        : sticky, a load contained a nibble above 9
// ---------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst_asyn_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q_out,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] atMax;
  logic [DIGITS-1:0] atMin;
  logic              atTerm;
  logic              countEn;
  logic              loadBad;

  logic ovf_q;
  logic ovf_d;
  logic load_err_q;
  logic load_err_d;

  // Whole counter sits at the terminal value for the current direction.
  assign atTerm = up_dn ? (&atMax) : (&atMin);

  // In saturate mode the terminal step is suppressed at the source so no
  // decade moves; in wrap mode the ripple chain naturally rolls every decade.
  assign countEn = en & ~((SATURATE != 0) & atTerm);

  assign tc = en & atTerm;

  // Ripple enable: a decade steps only when every lower decade is at the
  // rollover point for the current direction.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_first
        assign step[i] = countEn;
      end else begin : g_rest
        assign step[i] = step[i-1] & (up_dn ? atMax[i-1] : atMin[i-1]);
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rst_asyn_n (rst_asyn_n),
        .clr        (clr),
        .step       (step[i]),
        .up_dn      (up_dn),
        .load       (load),
        .load_nib   (load_val[DIGIT_W*i +: DIGIT_W]),
        .digit      (q_out[DIGIT_W*i +: DIGIT_W]),
        .at_max     (atMax[i]),
        .at_min     (atMin[i])
      );
    end
  endgenerate

  // Any nibble of the load word outside 0..9.
  always_comb begin
    loadBad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[DIGIT_W*i +: DIGIT_W])) begin
        loadBad = 1'b1;
      end
    end
  end

  // Sticky flags follow the same clr > load > en priority as the count.
  always_comb begin
    ovf_d      = ovf_q;
    load_err_d = load_err_q;
    if (clr) begin
      ovf_d      = 1'b0;
      load_err_d = 1'b0;
    end else if (load) begin
      if (loadBad) begin
        load_err_d = 1'b1;
      end
    end else if (en && atTerm) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_asyn_n) begin
    if (!rst_asyn_n) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
// Three counters share one set of controls: 4 decades wrapping, 4 decades
// saturating, and 1 decade wrapping (fed the low nibble of the load word).
// A decimal-integer reference model predicts each counter.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic        clk;
  logic        rstN;
  logic        en;
  logic        upDn;
  logic        clr;
  logic        load;
  logic [15:0] loadVal;

  logic [15:0] qA, qB;
  logic [3:0]  qC;
  logic        tcA, tcB, tcC;
  logic        ovfA, ovfB, ovfC;
  logic        errA, errB, errC;

  int compared;
  int mismatched;

  // Reference state: plain decimal values and flags.
  int mValA, mValB, mValC;
  bit mOvfA, mOvfB, mOvfC;
  bit mErrA, mErrB, mErrC;

  bcd_updown_counter #(.DIGITS(4), .SATURATE(0)) dutA (
    .clk(clk), .rst_asyn_n(rstN), .en(en), .up_dn(upDn), .clr(clr),
    .load(load), .load_val(loadVal), .q_out(qA), .tc(tcA), .ovf(ovfA),
    .load_err(errA)
  );

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1)) dutB (
    .clk(clk), .rst_asyn_n(rstN), .en(en), .up_dn(upDn), .clr(clr),
    .load(load), .load_val(loadVal), .q_out(qB), .tc(tcB), .ovf(ovfB),
    .load_err(errB)
  );

  bcd_updown_counter #(.DIGITS(1), .SATURATE(0)) dutC (
    .clk(clk), .rst_asyn_n(rstN), .en(en), .up_dn(upDn), .clr(clr),
    .load(load), .load_val(loadVal[3:0]), .q_out(qC), .tc(tcC), .ovf(ovfC),
    .load_err(errC)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int maxVal(input int digits);
    int m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [31:0] toBcd(input int v, input int digits);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of a load word, illegal nibbles read as 0.
  task automatic loadModel(input logic [15:0] lv, input int digits, output int val, output bit bad);
    logic [3:0] n;
    val = 0;
    bad = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      n = lv[4*i +: 4];
      if (n > 4'd9) begin
        bad = 1'b1;
        n = 4'd0;
      end
      val = val * 10 + int'(n);
    end
  endtask

  task automatic modelStep(input int digits, input bit sat, input logic [15:0] lv,
                           inout int val, inout bit ovf, inout bit err);
    int m;
    int lval;
    bit bad;
    m = maxVal(digits);
    if (clr) begin
      val = 0; ovf = 1'b0; err = 1'b0;
    end else if (load) begin
      loadModel(lv, digits, lval, bad);
      val = lval;
      if (bad) err = 1'b1;
    end else if (en) begin
      if (upDn) begin
        if (val == m) begin
          ovf = 1'b1;
          if (!sat) val = 0;
        end else val = val + 1;
      end else begin
        if (val == 0) begin
          ovf = 1'b1;
          if (!sat) val = m;
        end else val = val - 1;
      end
    end
  endtask

  function automatic bit expTc(input int val, input int digits);
    return en && (upDn ? (val == maxVal(digits)) : (val == 0));
  endfunction

  task automatic checkOutput();
    checkVal("qA", 32'(qA), toBcd(mValA, 4));
    checkVal("qB", 32'(qB), toBcd(mValB, 4));
    checkVal("qC", 32'(qC), toBcd(mValC, 1));
    checkVal("ovfA", 32'(ovfA), 32'(mOvfA));
    checkVal("ovfB", 32'(ovfB), 32'(mOvfB));
    checkVal("ovfC", 32'(ovfC), 32'(mOvfC));
    checkVal("errA", 32'(errA), 32'(mErrA));
    checkVal("errB", 32'(errB), 32'(mErrB));
    checkVal("errC", 32'(errC), 32'(mErrC));
  endtask

  task automatic modelReset();
    mValA = 0; mValB = 0; mValC = 0;
    mOvfA = 0; mOvfB = 0; mOvfC = 0;
    mErrA = 0; mErrB = 0; mErrC = 0;
  endtask

  // Drive one cycle of controls, check tc before the edge, then advance
  // the model and check registered outputs just after the edge.
  task automatic applyStimulus(input bit e, input bit u, input bit c, input bit l,
                               input logic [15:0] lv);
    en = e; upDn = u; clr = c; load = l; loadVal = lv;
    #1;
    checkVal("tcA", 32'(tcA), 32'(expTc(mValA, 4)));
    checkVal("tcB", 32'(tcB), 32'(expTc(mValB, 4)));
    checkVal("tcC", 32'(tcC), 32'(expTc(mValC, 1)));
    @(posedge clk);
    #1;
    modelStep(4, 1'b0, lv, mValA, mOvfA, mErrA);
    modelStep(4, 1'b1, lv, mValB, mOvfB, mErrB);
    modelStep(1, 1'b0, lv, mValC, mOvfC, mErrC);
    checkOutput();
  endtask

  initial begin
    logic [15:0] pick;
    compared = 0;
    mismatched = 0;
    rstN = 1'b0; en = 0; upDn = 1; clr = 0; load = 0; loadVal = '0;
    modelReset();
    #2;
    checkOutput();
    #10;
    rstN = 1'b1;

    // Up cascade across decades.
    applyStimulus(0, 1, 0, 1, 16'h0998);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("cascade1", 32'(qA), 32'h0999);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("cascade2", 32'(qA), 32'h1000);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("cascade3", 32'(qA), 32'h1001);

    // Wrap versus saturate at the top.
    applyStimulus(0, 1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 0, 1, 16'h9998);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    en = 1; upDn = 1; #1;
    checkVal("tcTop", 32'(tcA), 32'h1);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("wrapA", 32'(qA), 32'h0000);
    checkVal("wrapOvfA", 32'(ovfA), 32'h1);
    checkVal("satB", 32'(qB), 32'h9999);
    checkVal("satOvfB", 32'(ovfB), 32'h1);

    // Down count and bottom wrap.
    applyStimulus(0, 0, 1, 0, 16'h0000);
    applyStimulus(0, 0, 0, 1, 16'h1000);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkVal("down1", 32'(qA), 32'h0999);
    applyStimulus(0, 0, 0, 1, 16'h0001);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    en = 1; upDn = 0; #1;
    checkVal("tcBottom", 32'(tcA), 32'h1);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkVal("downWrap", 32'(qA), 32'h9999);
    checkVal("downOvf", 32'(ovfA), 32'h1);

    // Load error, then clear beats load and enable.
    applyStimulus(0, 1, 0, 1, 16'h12AF);
    checkVal("loadErrQ", 32'(qA), 32'h1200);
    checkVal("loadErrF", 32'(errA), 32'h1);
    applyStimulus(1, 1, 1, 1, 16'h5555);
    checkVal("clrQ", 32'(qA), 32'h0000);
    checkVal("clrErr", 32'(errA), 32'h0);

    // Direction toggling on the single-decade counter.
    applyStimulus(0, 1, 0, 1, 16'h0009);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("togC1", 32'(qC), 32'h0);
    checkVal("togOvfC", 32'(ovfC), 32'h1);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkVal("togC2", 32'(qC), 32'h9);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("togC3", 32'(qC), 32'h0);
    applyStimulus(0, 1, 0, 1, 16'h0005);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("fiveC1", 32'(qC), 32'h6);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkVal("fiveC2", 32'(qC), 32'h5);
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("fiveC3", 32'(qC), 32'h6);

    // Asynchronous reset mid-cycle.
    applyStimulus(0, 1, 0, 1, 16'h1234);
    checkVal("preRst", 32'(qA), 32'h1234);
    en = 1; load = 0;
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput();
    rstN = 1'b1;
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkVal("postRst", 32'(qA), 32'h0001);

    // Randomised run against the model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: pick = 16'($urandom);
        1: pick = 16'h9999;
        2: pick = 16'h9998;
        3: pick = 16'h0001;
        default: pick = 16'h0000;
      endcase
      applyStimulus(($urandom_range(0, 9) < 8), 1'($urandom),
                    ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0), pick);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
